// File: rtl/bu_pred.sv
// bu_pred: bimodal branch direction predictor with one-cycle registered branch resolve
// Ports: i_clk, i_rst_n (async active-low); predict i_pred_pc -> o_pred_taken (combinational);
// resolve i_res_valid/i_res_pc/i_a/i_b/i_op/i_res_pred/i_flush -> o_res_valid/o_take/o_mispredict (registered).
// Optional macro BU_PRED_STATS_EN adds o_br_cnt/o_mp_cnt saturating resolve and mispredict counters.
package cotm32_pkg;
  localparam int XLEN = 32;
  typedef enum logic [2:0] {
    BU_EQ  = 3'd0,
    BU_NE  = 3'd1,
    BU_LT  = 3'd2,
    BU_GE  = 3'd3,
    BU_LTU = 3'd4,
    BU_GEU = 3'd5
  } bu_op_t;
endpackage

module bu_pred #(
  parameter int XLEN    = cotm32_pkg::XLEN,
  parameter int ENTRIES = 64,
  parameter int CTR_W   = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [XLEN-1:0]    i_pred_pc,
  output logic               o_pred_taken,
  input  logic               i_res_valid,
  input  logic [XLEN-1:0]    i_res_pc,
  input  logic [XLEN-1:0]    i_a,
  input  logic [XLEN-1:0]    i_b,
  input  cotm32_pkg::bu_op_t i_op,
  input  logic               i_res_pred,
  input  logic               i_flush,
  output logic               o_res_valid,
  output logic               o_take,
  output logic               o_mispredict
`ifdef BU_PRED_STATS_EN
  ,
  output logic [31:0]        o_br_cnt,
  output logic [31:0]        o_mp_cnt
`endif
);
  import cotm32_pkg::*;
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
  logic [CTR_W-1:0] ctr_q [ENTRIES];
  logic [CTR_W-1:0] ctr_d [ENTRIES];
  logic [IDX_W-1:0] res_idx;
  logic [CTR_W-1:0] res_ctr;
  logic cond, legal, train;
  logic res_valid_d, res_valid_q, take_d, take_q, mp_d, mp_q;
  logic unused_pc;
  // Untagged table: only the word-index bits of either PC matter.
  assign unused_pc = ^{i_pred_pc[XLEN-1:IDX_W+2], i_pred_pc[1:0], i_res_pc[XLEN-1:IDX_W+2], i_res_pc[1:0]};
  assign o_pred_taken = ctr_q[i_pred_pc[IDX_W+1:2]][CTR_W-1];
  assign res_idx = i_res_pc[IDX_W+1:2];
  assign res_ctr = ctr_q[res_idx];
  assign train = i_res_valid & legal;
  always_comb begin
    legal = 1'b1;
    cond = 1'b0;
    case (i_op)
      BU_EQ:   cond = i_a == i_b;
      BU_NE:   cond = i_a != i_b;
      BU_LT:   cond = $signed(i_a) < $signed(i_b);
      BU_GE:   cond = $signed(i_a) >= $signed(i_b);
      BU_LTU:  cond = i_a < i_b;
      BU_GEU:  cond = i_a >= i_b;
      default: legal = 1'b0;
    endcase
  end
  // Training ignores flush: a flushed branch still resolved architecturally.
  always_comb begin
    ctr_d = ctr_q;
    if (train) ctr_d[res_idx] = cond ? (res_ctr == CTR_MAX ? res_ctr : res_ctr + 1'b1)
                                     : (res_ctr == '0 ? res_ctr : res_ctr - 1'b1);
  end
  assign res_valid_d = i_res_valid & ~i_flush;
  assign take_d = res_valid_d & cond;
  assign mp_d = res_valid_d & (cond ^ i_res_pred);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_INIT;
      res_valid_q <= 1'b0;
      take_q <= 1'b0;
      mp_q <= 1'b0;
    end else begin
      ctr_q <= ctr_d;
      res_valid_q <= res_valid_d;
      take_q <= take_d;
      mp_q <= mp_d;
    end
  end
  assign o_res_valid = res_valid_q;
  assign o_take = take_q;
  assign o_mispredict = mp_q;
`ifdef BU_PRED_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d, mp_cnt_q, mp_cnt_d;
  always_comb begin
    br_cnt_d = train && br_cnt_q != '1 ? br_cnt_q + 32'd1 : br_cnt_q;
    mp_cnt_d = train && (cond ^ i_res_pred) && mp_cnt_q != '1 ? mp_cnt_q + 32'd1 : mp_cnt_q;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end
  assign o_br_cnt = br_cnt_q;
  assign o_mp_cnt = mp_cnt_q;
`endif
endmodule
